// File: rtl/audio_stream_multichannel_frame_buffer.sv
// Multi-channel sample-set capture into a channel-interleaved circular RAM.
// Ports: CLK/RESET; BUFFER_ENABLE, SAMPLE_TRIG, SAMPLE_DATA, FLUSH in;
//   BUFFER_READ pops a word -> BUFFER_DATA/BUFFER_CHAN/BUFFER_VALID next cycle;
//   BUFFER_READY (>= one frame), FILL_LEVEL, sticky OVERFLOW (OVERFLOW_CLR).
module audio_stream_multichannel_frame_buffer #(
   parameter int DATA_WIDTH  = 16,
   parameter int CHANNELS    = 2,
   parameter int FRAME_SIZE  = 512,
   parameter int BUFFER_SIZE = 2048,
   localparam int AW = $clog2(BUFFER_SIZE),
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           BUFFER_ENABLE,
   input  logic                           SAMPLE_TRIG,
   input  logic [CHANNELS*DATA_WIDTH-1:0] SAMPLE_DATA,
   input  logic                           FLUSH,
   output logic                           BUFFER_READY,
   input  logic                           BUFFER_READ,
   output logic [DATA_WIDTH-1:0]          BUFFER_DATA,
   output logic [CW-1:0]                  BUFFER_CHAN,
   output logic                           BUFFER_VALID,
   output logic [AW:0]                    FILL_LEVEL,
   output logic                           OVERFLOW,
   input  logic                           OVERFLOW_CLR
);

   typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

   localparam logic [AW:0] SPACE_LIM   = (AW+1)'(BUFFER_SIZE - CHANNELS);
   localparam logic [AW:0] FRAME_WORDS = (AW+1)'(FRAME_SIZE * CHANNELS);
   localparam logic [CW-1:0] LAST_CH   = CW'(CHANNELS - 1);

   state_t                         state_q, state_d;
   logic [CHANNELS*DATA_WIDTH-1:0] cap_q, cap_d;
   logic [CW-1:0]                  chan_idx_q, chan_idx_d;
   logic [AW-1:0]                  head_q, head_d;
   logic [AW-1:0]                  tail_q, tail_d;
   logic [AW:0]                    count_q, count_d;
   logic [CW-1:0]                  tag_q, tag_d;
   logic                           valid_q, valid_d;
   logic                           ready_q, ready_d;
   logic                           ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0]          data_q, data_d;
   logic [CW-1:0]                  chan_q, chan_d;

   logic [DATA_WIDTH-1:0] mem [BUFFER_SIZE];

   logic                  trig_ok;
   logic                  space_ok;
   logic                  wr_en;
   logic                  rd_ok;
   logic                  drop;
   logic [DATA_WIDTH-1:0] wr_word;

   assign wr_word = cap_q[chan_idx_q*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      state_d    = state_q;
      cap_d      = cap_q;
      chan_idx_d = chan_idx_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      tag_d      = tag_q;
      data_d     = data_q;
      chan_d     = chan_q;
      ovf_d      = ovf_q;

      trig_ok  = SAMPLE_TRIG & BUFFER_ENABLE & ~FLUSH;
      space_ok = (count_q <= SPACE_LIM);
      wr_en    = (state_q == WRITE) & ~FLUSH;
      rd_ok    = BUFFER_READ & (count_q != '0) & ~FLUSH;
      drop     = trig_ok & ((state_q == WRITE) | ~space_ok);

      unique case (state_q)
         IDLE: begin
            if (trig_ok && space_ok) begin
               state_d    = WRITE;
               cap_d      = SAMPLE_DATA;
               chan_idx_d = '0;
            end
         end
         WRITE: begin
            if (chan_idx_q == LAST_CH) begin
               state_d = IDLE;
            end else begin
               chan_idx_d = chan_idx_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      if (wr_en) begin
         head_d = head_q + AW'(1);
      end

      if (rd_ok) begin
         tail_d = tail_q + AW'(1);
         data_d = mem[tail_q];
         chan_d = tag_q;
         tag_d  = (tag_q == LAST_CH) ? '0 : tag_q + CW'(1);
      end

      unique case ({wr_en, rd_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      valid_d = rd_ok;
      ready_d = (count_q >= FRAME_WORDS);

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (OVERFLOW_CLR) begin
         ovf_d = 1'b0;
      end

      if (FLUSH) begin
         state_d    = IDLE;
         chan_idx_d = '0;
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         tag_d      = '0;
         valid_d    = 1'b0;
         ready_d    = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= IDLE;
         cap_q      <= '0;
         chan_idx_q <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         tag_q      <= '0;
         valid_q    <= 1'b0;
         ready_q    <= 1'b0;
         ovf_q      <= 1'b0;
         data_q     <= '0;
         chan_q     <= '0;
      end else begin
         state_q    <= state_d;
         cap_q      <= cap_d;
         chan_idx_q <= chan_idx_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         tag_q      <= tag_d;
         valid_q    <= valid_d;
         ready_q    <= ready_d;
         ovf_q      <= ovf_d;
         data_q     <= data_d;
         chan_q     <= chan_d;
      end
   end

   // RAM array carries no reset; only committed words are ever read.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[head_q] <= wr_word;
      end
   end

   assign BUFFER_READY = ready_q;
   assign BUFFER_DATA  = data_q;
   assign BUFFER_CHAN  = chan_q;
   assign BUFFER_VALID = valid_q;
   assign FILL_LEVEL   = count_q;
   assign OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_audio_stream_multichannel_frame_buffer.sv
// Randomised directed bench for the multichannel frame buffer.
// A queue-based model of committed words predicts every output per cycle.
module tb_audio_stream_multichannel_frame_buffer;

   localparam int DW = 16;
   localparam int CH = 2;
   localparam int FS = 4;
   localparam int BS = 16;
   localparam int AW = 4;
   localparam int CW = 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            en;
   logic            trig;
   logic [CH*DW-1:0] sdata;
   logic            flush;
   logic            ready;
   logic            rd;
   logic [DW-1:0]   bdata;
   logic [CW-1:0]   bchan;
   logic            bvalid;
   logic [AW:0]     fill;
   logic            ovf;
   logic            ovf_clr;

   always #5 clk = ~clk;

   audio_stream_multichannel_frame_buffer #(
      .DATA_WIDTH (DW),
      .CHANNELS   (CH),
      .FRAME_SIZE (FS),
      .BUFFER_SIZE(BS)
   ) dut (
      .CLK          (clk),
      .RESET        (rst),
      .BUFFER_ENABLE(en),
      .SAMPLE_TRIG  (trig),
      .SAMPLE_DATA  (sdata),
      .FLUSH        (flush),
      .BUFFER_READY (ready),
      .BUFFER_READ  (rd),
      .BUFFER_DATA  (bdata),
      .BUFFER_CHAN  (bchan),
      .BUFFER_VALID (bvalid),
      .FILL_LEVEL   (fill),
      .OVERFLOW     (ovf),
      .OVERFLOW_CLR (ovf_clr)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } word_t;

   word_t         mq[$];
   word_t         pend[$];
   logic          m_valid;
   logic          m_ready;
   logic          m_ovf;
   logic [DW-1:0] m_data;
   logic [CW-1:0] m_chan;
   logic          en_r;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("fill", 32'(fill), 32'(mq.size()));
      chk("valid", 32'(bvalid), 32'(m_valid));
      chk("ready", 32'(ready), 32'(m_ready));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      if (m_valid) begin
         chk("data", 32'(bdata), 32'(m_data));
         chk("chan", 32'(bchan), 32'(m_chan));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_data"}, 32'(bdata), 32'd0);
      chk({tag, "_chan"}, 32'(bchan), 32'd0);
      chk({tag, "_valid"}, 32'(bvalid), 32'd0);
      chk({tag, "_fill"}, 32'(fill), 32'd0);
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf), 32'd0);
   endtask

   task automatic model_reset();
      mq.delete();
      pend.delete();
      m_valid = 1'b0;
      m_ready = 1'b0;
      m_ovf   = 1'b0;
   endtask

   task automatic step(input logic t, input logic [CH*DW-1:0] sd,
                       input logic r, input logic fl, input logic cl);
      int    pre;
      bit    busy;
      bit    acc;
      bit    drp;
      word_t w;
      trig    = t;
      sdata   = sd;
      rd      = r;
      flush   = fl;
      ovf_clr = cl;
      en      = en_r;
      @(posedge clk);
      pre  = mq.size();
      busy = pend.size() > 0;
      acc  = t && en_r && !fl && !busy && (pre <= BS - CH);
      drp  = t && en_r && !fl && (busy || pre > BS - CH);
      if (fl) begin
         mq.delete();
         pend.delete();
         m_valid = 1'b0;
         m_ready = 1'b0;
      end else begin
         m_ready = (pre >= FS * CH);
         m_valid = r && (pre > 0);
         if (m_valid) begin
            w      = mq.pop_front();
            m_data = w.d;
            m_chan = w.c;
         end
         if (busy) mq.push_back(pend.pop_front());
         if (acc) begin
            for (int c = 0; c < CH; c++) begin
               w.d = sd[c*DW +: DW];
               w.c = CW'(c);
               pend.push_back(w);
            end
         end
      end
      if (drp) m_ovf = 1'b1;
      else if (cl) m_ovf = 1'b0;
      #1;
      check_all();
      trig    = 1'b0;
      rd      = 1'b0;
      flush   = 1'b0;
      ovf_clr = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rnd_set();
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      idle(2);
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && mq.size() > 0; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      end
      idle(1);
   endtask

   initial begin
      rst     = 1'b1;
      en      = 1'b0;
      en_r    = 1'b0;
      trig    = 1'b0;
      sdata   = '0;
      flush   = 1'b0;
      rd      = 1'b0;
      ovf_clr = 1'b0;
      m_data  = '0;
      m_chan  = '0;
      model_reset();
      #2;
      check_zero("reset");
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: four directed sets, frame ready, ordered readback
      en_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1'b1, {16'(16'h2000 + k), 16'(16'h1000 + k)},
              1'b0, 1'b0, 1'b0);
         idle(3);
      end
      chk("frame_ready", 32'(ready), 32'd1);
      reads(8);
      idle(1);

      // 2: back-to-back triggers, overflow set and cleared
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      idle(2);
      chk("ovf_after_drop", 32'(ovf), 32'd1);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
      drain();

      // 3: fill to capacity, drop, reclaim, stream across wrap
      for (int k = 0; k < 8; k++) rnd_set();
      rnd_set();
      chk("full_fill", 32'(fill), 32'd16);
      reads(2);
      rnd_set();
      for (int i = 0; i < 80; i++) begin
         step($urandom_range(0, 2) == 0, $urandom(),
              $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      end
      idle(2);
      drain();

      // 4: read while empty; read during a write
      reads(1);
      rnd_set();
      rnd_set();
      reads(1);
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("rd_during_wr", 32'(fill), 32'd3);
      idle(1);
      drain();

      // 5: flush aborts a set mid-write
      for (int k = 0; k < 4; k++) rnd_set();
      idle(1);
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      idle(1);
      step(1'b1, $urandom(), 1'b0, 1'b1, 1'b0);
      chk("flush_fill", 32'(fill), 32'd0);
      rnd_set();
      reads(2);
      idle(1);

      // 6: async reset mid-set, then disabled triggers
      rnd_set();
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      idle(1);
      #3 rst = 1'b1;
      #1;
      check_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      en_r = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
         step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      end
      en_r = 1'b1;
      step(1'b1, $urandom(), 1'b0, 1'b0, 1'b0);
      en_r = 1'b0;
      idle(2);
      chk("en_drop_midset", 32'(fill), 32'd2);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
